map_collision: RTL

- Sits between the map ROM, hero position registers and the hero controller.
- Takes the 15x10 wall map and the hero's 12-bit pixel position, and works out which of the four movement directions are blocked by a wall tile.
- Drives the hero controller's collision[3:0], block_x_pos and block_y_pos inputs.
- Runs a short sequential probe scan on each start strobe (one per movement tick), one map lookup per clock.

---
 rtl/binary_land_pkg.sv | 32 +++
 rtl/map_tile_lookup.sv | 42 ++++
 rtl/map_collision.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/binary_land_pkg.sv
// Shared constants and types for the hero/map collision logic.
// Holds the map geometry, hero size, direction bit indices and the
// collision-scan FSM state type. No ports.
package binary_land_pkg;

    localparam int unsigned TILE_SIZE = 64;
    localparam int unsigned MAP_W     = 15;
    localparam int unsigned MAP_H     = 10;
    localparam int unsigned ORIGIN_X  = 32;
    localparam int unsigned ORIGIN_Y  = 64;
    localparam int unsigned HERO_SIZE = 48;

    localparam int unsigned TILE_SHIFT = $clog2(TILE_SIZE);
    localparam int unsigned MAP_BITS   = MAP_W * MAP_H;
    localparam int unsigned COL_W      = $clog2(MAP_W);
    localparam int unsigned ROW_W      = $clog2(MAP_H);
    localparam int unsigned IDX_W      = $clog2(MAP_BITS);

    // Bit positions in the collision vector; also the probe-index pair number.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StProbe,
        StDone
    } state_t;

endpackage

// File: rtl/map_tile_lookup.sv
// Combinational pixel-to-tile lookup.
// Ports:
//   i_px, i_py   13-bit signed probe pixel coordinates (screen space)
//   i_map        wall bitmap, bit (row*MAP_W+col), 1 = wall
//   o_col, o_row tile coordinates (meaningful only when o_in_bounds)
//   o_in_bounds  probe lies inside the map
//   o_wall       probe is in bounds and its tile is a wall
module map_tile_lookup
    import binary_land_pkg::*;
(
    input  logic [12:0]         i_px,
    input  logic [12:0]         i_py,
    input  logic [MAP_BITS-1:0] i_map,
    output logic [COL_W-1:0]    o_col,
    output logic [ROW_W-1:0]    o_row,
    output logic                o_in_bounds,
    output logic                o_wall
);

    logic [12:0]      w_dx;
    logic [12:0]      w_dy;
    logic [12:0]      w_col_full;
    logic [12:0]      w_row_full;
    logic [IDX_W-1:0] w_idx;

    assign w_dx = i_px - 13'(ORIGIN_X);
    assign w_dy = i_py - 13'(ORIGIN_Y);

    // Logical shift; negative offsets are rejected via the sign bit below.
    assign w_col_full = w_dx >> TILE_SHIFT;
    assign w_row_full = w_dy >> TILE_SHIFT;

    assign o_in_bounds = !w_dx[12] && !w_dy[12]
                         && (w_col_full < 13'(MAP_W)) && (w_row_full < 13'(MAP_H));

    assign o_col = w_col_full[COL_W-1:0];
    assign o_row = w_row_full[ROW_W-1:0];

    assign w_idx  = IDX_W'(o_row) * IDX_W'(MAP_W) + IDX_W'(o_col);
    assign o_wall = o_in_bounds && i_map[w_idx];

endmodule

// File: rtl/map_collision.sv
// Per-tick wall collision scan for the hero.
// On i_start (sampled in idle only) latches the hero position and map, then
// probes two points just beyond each hero edge, one map lookup per clock,
// and publishes the blocked-direction vector with a one-cycle o_valid.
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_start                      one-cycle scan request
//   i_map                        wall bitmap
//   i_hero_x_pos, i_hero_y_pos   hero top-left pixel
//   o_collision                  bit0 up, bit1 left, bit2 right, bit3 down
//   o_block_x_pos, o_block_y_pos pixel origin of first in-bounds wall hit
//   o_busy, o_valid              scan in progress, result-updated pulse
// Build option: MAP_BORDER_WALL_EN makes out-of-bounds probes count as blocked.
module map_collision
    import binary_land_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [MAP_BITS-1:0] i_map,
    input  logic [11:0]         i_hero_x_pos,
    input  logic [11:0]         i_hero_y_pos,
    output logic [3:0]          o_collision,
    output logic [11:0]         o_block_x_pos,
    output logic [11:0]         o_block_y_pos,
    output logic                o_busy,
    output logic                o_valid
);

    localparam logic [12:0] NEAR    = 13'(STEP);
    localparam logic [12:0] FAR_IN  = 13'(HERO_SIZE - 1);
    localparam logic [12:0] FAR_OUT = 13'(HERO_SIZE - 1 + STEP);

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_idx;
    logic [11:0]         r_hero_x;
    logic [11:0]         r_hero_y;
    logic [MAP_BITS-1:0] r_map;
    logic [3:0]          r_hits;
    logic                r_found;
    logic [COL_W-1:0]    r_hit_col;
    logic [ROW_W-1:0]    r_hit_row;
    logic [3:0]          r_collision;
    logic [11:0]         r_block_x;
    logic [11:0]         r_block_y;
    logic                r_valid;

    logic [12:0]         w_x;
    logic [12:0]         w_y;
    logic [12:0]         w_px;
    logic [12:0]         w_py;
    logic [COL_W-1:0]    w_col;
    logic [ROW_W-1:0]    w_row;
    logic                w_in_bounds;
    logic                w_wall;
    logic                w_hit;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StLatch;
            StLatch: w_state_next = StProbe;
            StProbe: if (r_idx == 3'd7) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Probe point for the current index; idx[2:1] selects the edge,
    // idx[0] selects the near or far corner along that edge.
    assign w_x = {1'b0, r_hero_x};
    assign w_y = {1'b0, r_hero_y};

    always_comb begin
        w_px = w_x;
        w_py = w_y;
        unique case (r_idx[2:1])
            DIR_UP: begin
                w_px = r_idx[0] ? w_x + FAR_IN : w_x;
                w_py = w_y - NEAR;
            end
            DIR_LEFT: begin
                w_px = w_x - NEAR;
                w_py = r_idx[0] ? w_y + FAR_IN : w_y;
            end
            DIR_RIGHT: begin
                w_px = w_x + FAR_OUT;
                w_py = r_idx[0] ? w_y + FAR_IN : w_y;
            end
            DIR_DOWN: begin
                w_px = r_idx[0] ? w_x + FAR_IN : w_x;
                w_py = w_y + FAR_OUT;
            end
            default: ;
        endcase
    end

    map_tile_lookup u_lookup (
        .i_px        (w_px),
        .i_py        (w_py),
        .i_map       (r_map),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_in_bounds (w_in_bounds),
        .o_wall      (w_wall)
    );

`ifdef MAP_BORDER_WALL_EN
    assign w_hit = w_wall | ~w_in_bounds;
`else
    assign w_hit = w_wall;
`endif

    // Datapath: latch inputs, accumulate hits, commit on DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx       <= '0;
            r_hero_x    <= '0;
            r_hero_y    <= '0;
            r_map       <= '0;
            r_hits      <= '0;
            r_found     <= 1'b0;
            r_hit_col   <= '0;
            r_hit_row   <= '0;
            r_collision <= '0;
            r_block_x   <= '0;
            r_block_y   <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StLatch: begin
                    r_hero_x <= i_hero_x_pos;
                    r_hero_y <= i_hero_y_pos;
                    r_map    <= i_map;
                    r_hits   <= '0;
                    r_found  <= 1'b0;
                    r_idx    <= '0;
                end
                StProbe: begin
                    if (w_hit) r_hits[r_idx[2:1]] <= 1'b1;
                    // Only real wall tiles report a block position
                    if (w_in_bounds && w_wall && !r_found) begin
                        r_found   <= 1'b1;
                        r_hit_col <= w_col;
                        r_hit_row <= w_row;
                    end
                    r_idx <= r_idx + 3'd1;
                end
                StDone: begin
                    r_collision <= r_hits;
                    r_valid     <= 1'b1;
                    if (r_found) begin
                        r_block_x <= 12'(ORIGIN_X) + (12'(r_hit_col) << TILE_SHIFT);
                        r_block_y <= 12'(ORIGIN_Y) + (12'(r_hit_row) << TILE_SHIFT);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_collision   = r_collision;
    assign o_block_x_pos = r_block_x;
    assign o_block_y_pos = r_block_y;
    assign o_busy        = (r_state != StIdle);
    assign o_valid       = r_valid;

endmodule
